// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencing FSM: edge/bit counters, check strobes, frame qualification
// Optional dropped-frame counter enabled by UART_RX_ERR_CNT_EN.
module uart_rx_ctrl #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_W-1:0]     Prescale,
    input  logic                      strt_glitch,
    input  logic                      par_error,
    input  logic                      stp_error,
    output logic [PRESCALE_W-1:0]     edge_cnt,
    output logic [$clog2(DATA_W)-1:0] bit_cnt,
    output logic                      dat_samp_en,
    output logic                      strt_chk_en,
    output logic                      deser_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic                      data_valid,
    output logic                      frame_err,
    output logic [7:0]                err_cnt
);
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t                r_state;
    logic [PRESCALE_W-1:0] r_edge;
    logic [PRESCALE_W-1:0] r_p;
    logic [BW-1:0]         r_bit;
    logic                  r_par_en;
    logic                  r_perr;
    logic                  r_strt_chk_en;
    logic                  r_deser_en;
    logic                  r_par_chk_en;
    logic                  r_stp_chk_en;

    logic [PRESCALE_W-1:0] w_p_dec;
    logic [PRESCALE_W-1:0] w_sp;
    logic [PRESCALE_W-1:0] w_spm1;
    logic [PRESCALE_W-1:0] w_ev;
    logic [PRESCALE_W-1:0] w_last;
    logic [PRESCALE_W-1:0] w_edge_inc;
    logic                  w_resolve;

    always_comb begin
        w_p_dec = PRESCALE_W'(8);
        if (Prescale == PRESCALE_W'(16))
            w_p_dec = PRESCALE_W'(16);
        else if (Prescale == PRESCALE_W'(32))
            w_p_dec = PRESCALE_W'(32);
    end

    assign w_sp       = (r_p >> 1) + PRESCALE_W'(2);
    assign w_spm1     = w_sp - PRESCALE_W'(1);
    assign w_ev       = w_sp + PRESCALE_W'(1);
    assign w_last     = r_p - PRESCALE_W'(1);
    assign w_edge_inc = (r_edge == w_last) ? '0 : r_edge + PRESCALE_W'(1);

    // stp_error is only valid in the EV cycle, so the frame verdict is decoded straight from it
    assign w_resolve  = (r_state == S_STOP) && (r_edge == w_ev);
    assign data_valid = w_resolve && !stp_error && !r_perr;
    assign frame_err  = w_resolve && (stp_error || r_perr);

    assign edge_cnt    = r_edge;
    assign bit_cnt     = r_bit;
    assign dat_samp_en = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PARITY) || (r_state == S_STOP);
    assign strt_chk_en = r_strt_chk_en;
    assign deser_en    = r_deser_en;
    assign par_chk_en  = r_par_chk_en;
    assign stp_chk_en  = r_stp_chk_en;

    // Strobes are registered one edge early so they coincide with edge_cnt==SP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_edge        <= '0;
            r_p           <= PRESCALE_W'(8);
            r_bit         <= '0;
            r_par_en      <= 1'b0;
            r_perr        <= 1'b0;
            r_strt_chk_en <= 1'b0;
            r_deser_en    <= 1'b0;
            r_par_chk_en  <= 1'b0;
            r_stp_chk_en  <= 1'b0;
        end else begin
            r_strt_chk_en <= 1'b0;
            r_deser_en    <= 1'b0;
            r_par_chk_en  <= 1'b0;
            r_stp_chk_en  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_edge <= '0;
                    r_bit  <= '0;
                    r_perr <= 1'b0;
                    if (!RX_IN) begin
                        r_state  <= S_START;
                        r_edge   <= PRESCALE_W'(1);
                        r_p      <= w_p_dec;
                        r_par_en <= PAR_EN;
                    end
                end
                S_START: begin
                    r_edge <= w_edge_inc;
                    if (r_edge == w_spm1)
                        r_strt_chk_en <= 1'b1;
                    if ((r_edge == w_ev) && strt_glitch) begin
                        r_state <= S_IDLE;
                        r_edge  <= '0;
                    end else if (r_edge == w_last) begin
                        r_state <= S_DATA;
                        r_bit   <= '0;
                    end
                end
                S_DATA: begin
                    r_edge <= w_edge_inc;
                    if (r_edge == w_spm1)
                        r_deser_en <= 1'b1;
                    if (r_edge == w_last) begin
                        if (r_bit == BW'(DATA_W - 1))
                            r_state <= r_par_en ? S_PARITY : S_STOP;
                        else
                            r_bit <= r_bit + BW'(1);
                    end
                end
                S_PARITY: begin
                    r_edge <= w_edge_inc;
                    if (r_edge == w_spm1)
                        r_par_chk_en <= 1'b1;
                    if (r_edge == w_ev)
                        r_perr <= par_error;
                    if (r_edge == w_last)
                        r_state <= S_STOP;
                end
                S_STOP: begin
                    r_edge <= w_edge_inc;
                    if (r_edge == w_spm1)
                        r_stp_chk_en <= 1'b1;
                    if (r_edge == w_ev) begin
                        r_state <= stp_error ? S_WAIT_IDLE : S_IDLE;
                        r_edge  <= '0;
                    end
                end
                S_WAIT_IDLE: begin
                    r_edge <= '0;
                    if (RX_IN)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_edge  <= '0;
                end
            endcase
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err_cnt <= 8'h00;
        else if (frame_err && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl with models of the upstream check blocks
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       strt_glitch;
    logic       par_error;
    logic       stp_error;
    logic [5:0] edge_cnt;
    logic [2:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       frame_err;
    logic [7:0] err_cnt;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
        int         ev;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         cur_sp = 6;
    int         fdeser = 0;
    int         n_strt = 0;
    int         exp_err = 0;
    logic [7:0] cap;

`ifdef UART_RX_ERR_CNT_EN
    localparam int N_BAD = 300;
`else
    localparam int N_BAD = 3;
`endif

    uart_rx_ctrl #(.DATA_W(8), .PRESCALE_W(6)) dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
        .strt_glitch(strt_glitch), .par_error(par_error), .stp_error(stp_error),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid), .frame_err(frame_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Registered start/parity/stop checkers and deserializer, as the real datapath provides them
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            strt_glitch <= 1'b0;
            par_error   <= 1'b0;
            stp_error   <= 1'b0;
            cap         <= 8'h00;
        end else begin
            if (strt_chk_en) strt_glitch <= RX_IN;
            if (deser_en)    cap         <= {RX_IN, cap[7:1]};
            if (par_chk_en)  par_error   <= (RX_IN != ^cap);
            if (stp_chk_en)  stp_error   <= ~RX_IN;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_errcnt();
`ifdef UART_RX_ERR_CNT_EN
        return exp_err;
`else
        return 0;
`endif
    endfunction

    task automatic chk_zero(input string name);
        chk(name, {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
                   stp_chk_en, data_valid, frame_err, err_cnt}, 32'h0);
    endtask

    task automatic hold(input logic v, input int n);
        RX_IN = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic bad_par,
                              input logic [5:0] pset, input int p, input int stop_low);
        exp_t e;
        cur_sp = p / 2 + 2;
        e.kind = (bad_par || stop_low > 0) ? 2'b01 : 2'b10;
        e.data = d;
        e.ev   = cur_sp + 1;
        q.push_back(e);
        if (e.kind == 2'b01 && exp_err < 255) exp_err++;
        Prescale = pset;
        PAR_EN   = pe;
        hold(1'b0, 2);
        Prescale = 6'd5;
        PAR_EN   = ~pe;
        hold(1'b0, p - 2);
        for (int i = 0; i < 8; i++) hold(d[i], p);
        if (pe) hold((^d) ^ bad_par, p);
        if (stop_low > 0) begin
            hold(1'b0, p + 1);
            chk("wait_idle_hold", {dat_samp_en, edge_cnt}, 32'h0);
            hold(1'b0, stop_low * p - p - 1);
        end
        hold(1'b1, p);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (strt_chk_en) n_strt++;
            if (deser_en) fdeser++;
            if (strt_chk_en || deser_en || par_chk_en || stp_chk_en) begin
                chk("strobe_edge", edge_cnt, cur_sp);
                chk("strobe_samp_en", dat_samp_en, 1'b1);
                chk("strobe_no_evt", {data_valid, frame_err}, 2'b00);
            end
            if (data_valid || frame_err) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_evt: got dv=%0b fe=%0b expected none at %0t",
                             data_valid, frame_err, $time);
                end else begin
                    e = q.pop_front();
                    chk("evt_kind", {data_valid, frame_err}, e.kind);
                    chk("evt_edge", edge_cnt, e.ev);
                    if (e.kind == 2'b10) begin
                        chk("rx_data", cap, e.data);
                        chk("deser_cnt", fdeser, 8);
                    end
                end
                fdeser = 0;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish by %0t expected finish", $time);
        $fatal(1);
    end

    initial begin : stim
        int n0;
        rst      = 1'b1;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        Prescale = 6'd8;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_state");
        rst = 1'b0;
        hold(1'b1, 4);

        send_frame(8'hA5, 1'b0, 1'b0, 6'd8, 8, 0);
        hold(1'b1, 5);

        send_frame(8'h3C, 1'b1, 1'b0, 6'd16, 16, 0);
        hold(1'b1, 5);
        send_frame(8'h3C, 1'b1, 1'b1, 6'd16, 16, 0);
        chk("err_cnt_par", err_cnt, exp_errcnt());
        hold(1'b1, 5);

        cur_sp   = 6;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        n0       = n_strt;
        hold(1'b0, 2);
        hold(1'b1, 30);
        chk("glitch_strt_seen", n_strt - n0, 1);
        chk("glitch_no_deser", fdeser, 0);
        chk("glitch_idle", {dat_samp_en, edge_cnt}, 32'h0);

        send_frame(8'h5A, 1'b0, 1'b0, 6'd8, 8, 3);
        send_frame(8'h81, 1'b0, 1'b0, 6'd8, 8, 0);
        chk("err_cnt_stop", err_cnt, exp_errcnt());
        hold(1'b1, 5);

        send_frame(8'h12, 1'b0, 1'b0, 6'd32, 32, 0);
        send_frame(8'hED, 1'b0, 1'b0, 6'd32, 32, 0);
        hold(1'b1, 5);

        send_frame(8'h0F, 1'b0, 1'b0, 6'd12, 8, 0);
        hold(1'b1, 5);

        cur_sp   = 10;
        Prescale = 6'd16;
        PAR_EN   = 1'b1;
        hold(1'b0, 16);
        for (int i = 0; i < 4; i++) hold(1'b1, 16);
        hold(1'b0, 8);
        chk("bit_cnt_before_rst", bit_cnt, 3'd4);
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        exp_err = 0;
        hold(1'b1, 3);
        rst    = 1'b0;
        fdeser = 0;
        hold(1'b1, 5);
        send_frame(8'hC3, 1'b1, 1'b0, 6'd16, 16, 0);
        hold(1'b1, 5);

        for (int i = 0; i < N_BAD; i++) send_frame(8'h99, 1'b1, 1'b1, 6'd8, 8, 0);
        hold(1'b1, 5);
        chk("err_cnt_sat", err_cnt, exp_errcnt());

        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
